kernel_interrupt_arbiter: RTL and testbench

- Sits directly downstream of the per-kernel helper blocks.
- Captures each kernel's one-cycle interrupt request pulse with its 64-bit source and context.
- Arbitrates round-robin among NUM_KERNELS kernels and issues one request at a time to the host interrupt port, retrying on host error.
- Returns a one-cycle ack pulse to the originating kernel once the host accepts the interrupt.

---
 rtl/kernel_interrupt_arbiter_if.sv | 27 ++
 rtl/kernel_interrupt_arbiter.sv | 217 +++++++++++++++++++++
 tb/tb_kernel_interrupt_arbiter.sv | 556 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/kernel_interrupt_arbiter_if.sv
// Host-side interrupt port of the kernel interrupt arbiter.
// The arbiter drives the request and its payload; the host answers with ack/err.
interface kernel_interrupt_arbiter_if #(
  parameter int CTXW = 9
);
  logic            host_intr_req;
  logic [63:0]     host_intr_src;
  logic [CTXW-1:0] host_intr_ctx;
  logic            host_intr_ack;
  logic            host_intr_err;

  modport master (
    output host_intr_req,
    output host_intr_src,
    output host_intr_ctx,
    input  host_intr_ack,
    input  host_intr_err
  );

  modport slave (
    input  host_intr_req,
    input  host_intr_src,
    input  host_intr_ctx,
    output host_intr_ack,
    output host_intr_err
  );
endinterface

// File: rtl/kernel_interrupt_arbiter.sv
// Captures per-kernel interrupt pulses and forwards them one at a time, round-robin, to the host.
// Optional host ack timeout is enabled by defining KERNEL_INTR_TIMEOUT_EN.
module kernel_interrupt_arbiter #(
  parameter int NUM_KERNELS    = 4,
  parameter int CTXW           = 9,
  parameter int RETRY_DELAY    = 16,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_KERNELS-1:0]        kern_intr_req,
  input  logic [64*NUM_KERNELS-1:0]     kern_intr_src,
  input  logic [CTXW*NUM_KERNELS-1:0]   kern_intr_ctx,
  output logic [NUM_KERNELS-1:0]        kern_intr_ack,
  kernel_interrupt_arbiter_if.master    host,
  output logic [NUM_KERNELS-1:0]        overrun_err,
`ifdef KERNEL_INTR_TIMEOUT_EN
  output logic [NUM_KERNELS-1:0]        timeout_err,
`endif
  output logic                          busy
);

  localparam int GW = $clog2(NUM_KERNELS);
  localparam int RW = $clog2(RETRY_DELAY + 1);

  if (NUM_KERNELS < 2 || NUM_KERNELS > 16 || RETRY_DELAY < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_params
    $error("kernel_interrupt_arbiter: parameter out of range");
  end

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT_RETRY,
    DONE
  } state_t;

  state_t          state, next_state;

  logic [NUM_KERNELS-1:0] pend;
  logic [63:0]            src_slot [NUM_KERNELS];
  logic [CTXW-1:0]        ctx_slot [NUM_KERNELS];

  logic [GW-1:0]   grant, last_grant;
  logic [RW-1:0]   retry_cnt;
  logic [63:0]     req_src;
  logic [CTXW-1:0] req_ctx;

  logic            arb_valid;
  logic [GW-1:0]   arb_idx;
  logic [GW-1:0]   cand;

  logic            start_req;
  logic            retry_load;
  logic            done_pulse;
  logic            req_level;
  logic            timeout_hit;

  // Increment with explicit wrap so non-power-of-two kernel counts never select a missing slot.
  function automatic logic [GW-1:0] next_idx(input logic [GW-1:0] idx);
    if (idx == GW'(NUM_KERNELS - 1)) begin
      return '0;
    end
    return idx + 1'b1;
  endfunction

  always_comb begin
    arb_valid = 1'b0;
    arb_idx   = '0;
    cand      = last_grant;
    for (int k = 0; k < NUM_KERNELS; k++) begin
      cand = next_idx(cand);
      if (!arb_valid && pend[cand]) begin
        arb_valid = 1'b1;
        arb_idx   = cand;
      end
    end
  end

`ifdef KERNEL_INTR_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] to_cnt;

  // Held at zero outside REQ so every entry into REQ starts a fresh timeout window.
  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt      <= '0;
      timeout_err <= '0;
    end else begin
      if (state == REQ) begin
        to_cnt <= to_cnt + 1'b1;
      end else begin
        to_cnt <= '0;
      end
      for (int i = 0; i < NUM_KERNELS; i++) begin
        if (timeout_hit && grant == GW'(i)) begin
          timeout_err[i] <= 1'b1;
        end
      end
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state    = state;
    start_req     = 1'b0;
    retry_load    = 1'b0;
    done_pulse    = 1'b0;
    req_level     = 1'b0;
    timeout_hit   = 1'b0;
    kern_intr_ack = '0;
    case (state)
      IDLE: begin
        if (arb_valid) begin
          start_req  = 1'b1;
          next_state = REQ;
        end
      end
      REQ: begin
        req_level = 1'b1;
        if (host.host_intr_ack) begin
          if (host.host_intr_err) begin
            retry_load = 1'b1;
            next_state = WAIT_RETRY;
          end else begin
            next_state = DONE;
          end
        end
`ifdef KERNEL_INTR_TIMEOUT_EN
        else if (to_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
          timeout_hit = 1'b1;
          next_state  = DONE;
        end
`endif
      end
      WAIT_RETRY: begin
        if (retry_cnt == RW'(1)) begin
          next_state = REQ;
        end
      end
      DONE: begin
        done_pulse = 1'b1;
        for (int i = 0; i < NUM_KERNELS; i++) begin
          if (grant == GW'(i)) begin
            kern_intr_ack[i] = 1'b1;
          end
        end
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Grant and the host payload are captured once per arbitration and held through any retries.
  always_ff @(posedge clk) begin
    if (rst) begin
      grant      <= '0;
      last_grant <= GW'(NUM_KERNELS - 1);
      retry_cnt  <= '0;
      req_src    <= '0;
      req_ctx    <= '0;
    end else begin
      if (start_req) begin
        grant   <= arb_idx;
        req_src <= src_slot[arb_idx];
        req_ctx <= ctx_slot[arb_idx];
      end
      if (retry_load) begin
        retry_cnt <= RW'(RETRY_DELAY);
      end else if (state == WAIT_RETRY) begin
        retry_cnt <= retry_cnt - 1'b1;
      end
      if (done_pulse) begin
        last_grant <= grant;
      end
    end
  end

  // A pulse landing in the same cycle as that kernel's ack refills the slot instead of overrunning.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend        <= '0;
      overrun_err <= '0;
      for (int i = 0; i < NUM_KERNELS; i++) begin
        src_slot[i] <= '0;
        ctx_slot[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_KERNELS; i++) begin
        if (kern_intr_req[i]) begin
          if (pend[i] && !kern_intr_ack[i]) begin
            overrun_err[i] <= 1'b1;
          end else begin
            pend[i]     <= 1'b1;
            src_slot[i] <= kern_intr_src[64*i +: 64];
            ctx_slot[i] <= kern_intr_ctx[CTXW*i +: CTXW];
          end
        end else if (kern_intr_ack[i]) begin
          pend[i] <= 1'b0;
        end
      end
    end
  end

  assign host.host_intr_req = req_level;
  assign host.host_intr_src = req_src;
  assign host.host_intr_ctx = req_ctx;
  assign busy               = (state != IDLE) || (|pend);

endmodule

// File: tb/tb_kernel_interrupt_arbiter.sv
// Self-checking bench for kernel_interrupt_arbiter: directed scenarios plus a randomized run
// against a transaction-level reference model. Define KERNEL_INTR_TIMEOUT_EN to cover the timeout.
module tb_kernel_interrupt_arbiter;

  localparam int NK   = 4;
  localparam int CTXW = 9;
  localparam int RD   = 16;
  localparam int TO   = 64;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [NK-1:0]        kern_intr_req = '0;
  logic [64*NK-1:0]     kern_intr_src = '0;
  logic [CTXW*NK-1:0]   kern_intr_ctx = '0;
  logic [NK-1:0]        kern_intr_ack;
  logic [NK-1:0]        overrun_err;
  logic                 busy;
`ifdef KERNEL_INTR_TIMEOUT_EN
  logic [NK-1:0]        timeout_err;
`endif

  int errors = 0;
  int checks = 0;

  logic [63:0]     sent_src [NK];
  logic [CTXW-1:0] sent_ctx [NK];
  int              served_k [32];
  logic [NK-1:0]   kack_vec [32];
  int              served_n;
  int              kack_n;

  kernel_interrupt_arbiter_if #(.CTXW(CTXW)) host_bus ();

  kernel_interrupt_arbiter #(
    .NUM_KERNELS   (NK),
    .CTXW          (CTXW),
    .RETRY_DELAY   (RD),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .kern_intr_req(kern_intr_req),
    .kern_intr_src(kern_intr_src),
    .kern_intr_ctx(kern_intr_ctx),
    .kern_intr_ack(kern_intr_ack),
    .host         (host_bus),
    .overrun_err  (overrun_err),
`ifdef KERNEL_INTR_TIMEOUT_EN
    .timeout_err  (timeout_err),
`endif
    .busy         (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_kernel(input int k, input logic [63:0] s, input logic [CTXW-1:0] c);
    kern_intr_req[k]              = 1'b1;
    kern_intr_src[64*k +: 64]     = s;
    kern_intr_ctx[CTXW*k +: CTXW] = c;
    sent_src[k]                   = s;
    sent_ctx[k]                   = c;
  endtask

  task automatic do_reset();
    rst                    = 1'b1;
    kern_intr_req          = '0;
    host_bus.host_intr_ack = 1'b0;
    host_bus.host_intr_err = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Behaves as a host that accepts every request one cycle after it appears; records what it saw.
  task automatic run_host(input int n, input int max_cycles);
    bit ack_now;
    int id;
    ack_now  = 1'b0;
    served_n = 0;
    kack_n   = 0;
    for (int i = 0; i < 32; i++) begin
      served_k[i] = -1;
      kack_vec[i] = '0;
    end
    for (int c = 0; c < max_cycles && kack_n < n; c++) begin
      tick();
      host_bus.host_intr_ack = ack_now;
      host_bus.host_intr_err = 1'b0;
      @(negedge clk);
      if (kern_intr_ack != '0 && kack_n < 32) begin
        kack_vec[kack_n] = kern_intr_ack;
        kack_n++;
      end
      ack_now = 1'b0;
      if (host_bus.host_intr_req && !host_bus.host_intr_ack && served_n < 32) begin
        id = -1;
        for (int k = 0; k < NK; k++) begin
          if (host_bus.host_intr_src == sent_src[k] && host_bus.host_intr_ctx == sent_ctx[k]) id = k;
        end
        served_k[served_n] = id;
        served_n++;
        ack_now = 1'b1;
      end
    end
    tick();
    host_bus.host_intr_ack = 1'b0;
  endtask

  task automatic wait_for_req(output bit got);
    got = 1'b0;
    for (int c = 0; c < 10 && !got; c++) begin
      @(negedge clk);
      if (host_bus.host_intr_req) got = 1'b1;
      else tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int k = 0; k < NK; k++) set_kernel(k, {$urandom, $urandom}, CTXW'($urandom));
    host_bus.host_intr_ack = 1'b1;
    host_bus.host_intr_err = 1'b0;
    tick();
    tick();
    @(negedge clk);
    checks++;
    if ({host_bus.host_intr_req, kern_intr_ack, busy, overrun_err} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got req=%b ack=%b busy=%b ovr=%b, expected all 0",
               host_bus.host_intr_req, kern_intr_ack, busy, overrun_err);
    end
    checks++;
    if (host_bus.host_intr_src !== 64'h0 || host_bus.host_intr_ctx !== '0) begin
      errors++;
      $display("[TB] FAIL reset_payload: got src=%h ctx=%h, expected 0", host_bus.host_intr_src, host_bus.host_intr_ctx);
    end
    do_reset();
  endtask

  task automatic test_single();
    do_reset();
    set_kernel(1, 64'h0000_0001_DEAD_BEEF, 9'h05);
    tick();
    kern_intr_req = '0;
    @(negedge clk);
    checks++;
    if (host_bus.host_intr_req !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL single_t1: got req=%b busy=%b, expected req=0 busy=1", host_bus.host_intr_req, busy);
    end
    tick();
    @(negedge clk);
    checks++;
    if (host_bus.host_intr_req !== 1'b1 || host_bus.host_intr_src !== 64'h0000_0001_DEAD_BEEF ||
        host_bus.host_intr_ctx !== 9'h05) begin
      errors++;
      $display("[TB] FAIL single_t2: got req=%b src=%h ctx=%h, expected 1 00000001deadbeef 005",
               host_bus.host_intr_req, host_bus.host_intr_src, host_bus.host_intr_ctx);
    end
    tick();
    tick();
    host_bus.host_intr_ack = 1'b1;
    @(negedge clk);
    checks++;
    if (kern_intr_ack !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL single_t4_ack: got %b expected 0000", kern_intr_ack);
    end
    tick();
    host_bus.host_intr_ack = 1'b0;
    @(negedge clk);
    checks++;
    if (kern_intr_ack !== 4'b0010 || host_bus.host_intr_req !== 1'b0) begin
      errors++;
      $display("[TB] FAIL single_t5: got ack=%b req=%b, expected ack=0010 req=0", kern_intr_ack, host_bus.host_intr_req);
    end
    tick();
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || kern_intr_ack !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL single_t6: got busy=%b ack=%b, expected busy=0 ack=0000", busy, kern_intr_ack);
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    for (int k = 0; k < NK; k++) set_kernel(k, {$urandom, $urandom} ^ 64'(k), CTXW'($urandom));
    tick();
    kern_intr_req = '0;
    run_host(4, 100);
    checks++;
    if (kack_n !== 4 || served_n !== 4) begin
      errors++;
      $display("[TB] FAIL simul_count: got acks=%0d served=%0d, expected 4 4", kack_n, served_n);
    end
    for (int i = 0; i < NK; i++) begin
      checks++;
      if (served_k[i] !== i || kack_vec[i] !== NK'(1) << i) begin
        errors++;
        $display("[TB] FAIL simul_order[%0d]: got kernel=%0d ack=%b, expected kernel=%0d", i, served_k[i], kack_vec[i], i);
      end
    end
    checks++;
    if (overrun_err !== '0) begin
      errors++;
      $display("[TB] FAIL simul_overrun: got %b expected 0000", overrun_err);
    end
  endtask

  task automatic test_fairness();
    bit got;
    do_reset();
    set_kernel(2, {$urandom, $urandom}, CTXW'($urandom));
    tick();
    kern_intr_req = '0;
    wait_for_req(got);
    checks++;
    if (!got || host_bus.host_intr_src !== sent_src[2]) begin
      errors++;
      $display("[TB] FAIL fair_first: got req_seen=%b src=%h, expected 1 %h", got, host_bus.host_intr_src, sent_src[2]);
    end
    tick();
    set_kernel(0, {$urandom, $urandom} ^ 64'h1, CTXW'($urandom));
    set_kernel(3, {$urandom, $urandom} ^ 64'h3, CTXW'($urandom));
    host_bus.host_intr_ack = 1'b1;
    tick();
    kern_intr_req          = '0;
    host_bus.host_intr_ack = 1'b0;
    @(negedge clk);
    checks++;
    if (kern_intr_ack !== 4'b0100) begin
      errors++;
      $display("[TB] FAIL fair_ack2: got %b expected 0100", kern_intr_ack);
    end
    run_host(2, 60);
    checks++;
    if (served_k[0] !== 3 || served_k[1] !== 0) begin
      errors++;
      $display("[TB] FAIL fair_order: got %0d,%0d expected 3,0", served_k[0], served_k[1]);
    end
  endtask

  task automatic test_retry();
    bit got;
    bit seen;
    bit kack_bad;
    int low;
    int k;
    logic [63:0] s;
    logic [CTXW-1:0] cv;
    do_reset();
    k  = $urandom_range(0, NK-1);
    s  = {$urandom, $urandom};
    cv = CTXW'($urandom);
    set_kernel(k, s, cv);
    tick();
    kern_intr_req = '0;
    wait_for_req(got);
    tick();
    host_bus.host_intr_ack = 1'b1;
    host_bus.host_intr_err = 1'b1;
    tick();
    host_bus.host_intr_ack = 1'b0;
    host_bus.host_intr_err = 1'b0;
    low      = 0;
    seen     = 1'b0;
    kack_bad = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      @(negedge clk);
      if (kern_intr_ack !== '0) kack_bad = 1'b1;
      if (host_bus.host_intr_req) seen = 1'b1;
      else begin
        low++;
        tick();
      end
    end
    checks++;
    if (!got || !seen || low !== RD) begin
      errors++;
      $display("[TB] FAIL retry_gap: got first=%b again=%b low_cycles=%0d, expected 1 1 %0d", got, seen, low, RD);
    end
    checks++;
    if (host_bus.host_intr_src !== s || host_bus.host_intr_ctx !== cv || kack_bad) begin
      errors++;
      $display("[TB] FAIL retry_payload: got src=%h ctx=%h early_ack=%b, expected %h %h 0",
               host_bus.host_intr_src, host_bus.host_intr_ctx, kack_bad, s, cv);
    end
    tick();
    host_bus.host_intr_ack = 1'b1;
    tick();
    host_bus.host_intr_ack = 1'b0;
    @(negedge clk);
    checks++;
    if (kern_intr_ack !== NK'(1) << k) begin
      errors++;
      $display("[TB] FAIL retry_ack: got %b expected %b", kern_intr_ack, NK'(1) << k);
    end
  endtask

  task automatic test_overrun();
    logic [63:0] src_a;
    logic [CTXW-1:0] ctx_a;
    do_reset();
    src_a = {$urandom, $urandom};
    ctx_a = CTXW'($urandom);
    set_kernel(2, src_a, ctx_a);
    tick();
    set_kernel(2, ~src_a, ctx_a + 1'b1);
    sent_src[2] = src_a;
    sent_ctx[2] = ctx_a;
    tick();
    kern_intr_req = '0;
    run_host(2, 40);
    checks++;
    if (served_n !== 1 || served_k[0] !== 2) begin
      errors++;
      $display("[TB] FAIL overrun_payload: got served=%0d kernel=%0d, expected 1 2", served_n, served_k[0]);
    end
    checks++;
    if (kack_n !== 1 || kack_vec[0] !== 4'b0100) begin
      errors++;
      $display("[TB] FAIL overrun_acks: got count=%0d first=%b, expected 1 0100", kack_n, kack_vec[0]);
    end
    checks++;
    if (overrun_err !== 4'b0100) begin
      errors++;
      $display("[TB] FAIL overrun_flag: got %b expected 0100", overrun_err);
    end
  endtask

  task automatic test_reset_mid_req();
    bit got;
    bit stray;
    do_reset();
    set_kernel(0, {$urandom, $urandom}, CTXW'($urandom));
    set_kernel(1, {$urandom, $urandom}, CTXW'($urandom));
    set_kernel(3, {$urandom, $urandom}, CTXW'($urandom));
    tick();
    kern_intr_req = '0;
    wait_for_req(got);
    checks++;
    if (!got || busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL midrst_pre: got req_seen=%b busy=%b, expected 1 1", got, busy);
    end
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({host_bus.host_intr_req, kern_intr_ack, busy, overrun_err} !== '0 ||
        host_bus.host_intr_src !== 64'h0 || host_bus.host_intr_ctx !== '0) begin
      errors++;
      $display("[TB] FAIL midrst_outputs: got req=%b ack=%b busy=%b ovr=%b src=%h, expected all 0",
               host_bus.host_intr_req, kern_intr_ack, busy, overrun_err, host_bus.host_intr_src);
    end
    stray = 1'b0;
    for (int c = 0; c < 8; c++) begin
      tick();
      @(negedge clk);
      if (host_bus.host_intr_req || kern_intr_ack !== '0 || busy) stray = 1'b1;
    end
    checks++;
    if (stray) begin
      errors++;
      $display("[TB] FAIL midrst_dropped: got activity=%b expected 0", stray);
    end
    tick();
    set_kernel(0, {$urandom, $urandom}, CTXW'($urandom));
    tick();
    kern_intr_req = '0;
    run_host(1, 20);
    checks++;
    if (served_k[0] !== 0 || kack_n !== 1 || kack_vec[0] !== 4'b0001) begin
      errors++;
      $display("[TB] FAIL midrst_after: got kernel=%0d acks=%0d ack=%b, expected 0 1 0001", served_k[0], kack_n, kack_vec[0]);
    end
  endtask

`ifdef KERNEL_INTR_TIMEOUT_EN
  task automatic test_timeout();
    bit got;
    bit done;
    int hi;
    do_reset();
    set_kernel(1, {$urandom, $urandom}, CTXW'($urandom));
    tick();
    kern_intr_req = '0;
    wait_for_req(got);
    hi   = 0;
    done = 1'b0;
    for (int c = 0; c < 200 && !done; c++) begin
      if (host_bus.host_intr_req) begin
        hi++;
        tick();
        @(negedge clk);
      end else begin
        done = 1'b1;
      end
    end
    checks++;
    if (!got || hi !== TO) begin
      errors++;
      $display("[TB] FAIL timeout_len: got req_cycles=%0d expected %0d", hi, TO);
    end
    checks++;
    if (kern_intr_ack !== 4'b0010 || timeout_err !== 4'b0010) begin
      errors++;
      $display("[TB] FAIL timeout_ack: got ack=%b terr=%b, expected 0010 0010", kern_intr_ack, timeout_err);
    end
  endtask
`endif

  function automatic int arb_pick(input logic [NK-1:0] p, input int last);
    for (int off = 1; off <= NK; off++) begin
      if (p[(last + off) % NK]) return (last + off) % NK;
    end
    return -1;
  endfunction

  // Model: pending slots plus one outstanding transaction with a forced-low gap after host errors.
  task automatic test_random(input int ncyc);
    logic [NK-1:0]   pend_m, over_m, kack_e, kreq;
    logic [63:0]     src_m [NK];
    logic [CTXW-1:0] ctx_m [NK];
    logic [63:0]     cur_src;
    logic [CTXW-1:0] cur_ctx;
    int  txn_k, ack_due, gap, last_m;
    bit  exp_req, hack, herr, busy_e;
    do_reset();
    pend_m  = '0;
    over_m  = '0;
    txn_k   = -1;
    ack_due = -1;
    gap     = 0;
    last_m  = NK - 1;
    exp_req = 1'b0;
    cur_src = '0;
    cur_ctx = '0;
    for (int k = 0; k < NK; k++) begin
      src_m[k] = '0;
      ctx_m[k] = '0;
    end
    for (int n = 0; n < ncyc; n++) begin
      tick();
      for (int k = 0; k < NK; k++) begin
        kreq[k]                       = ($urandom_range(0, 5) == 0);
        kern_intr_src[64*k +: 64]     = {$urandom, $urandom};
        kern_intr_ctx[CTXW*k +: CTXW] = CTXW'($urandom);
      end
      kern_intr_req          = kreq;
      hack                   = exp_req ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
      herr                   = ($urandom_range(0, 3) == 0);
      host_bus.host_intr_ack = hack;
      host_bus.host_intr_err = herr;
      @(negedge clk);
      kack_e = '0;
      if (ack_due >= 0) kack_e[ack_due] = 1'b1;
      busy_e = (pend_m != '0) || (txn_k >= 0) || (ack_due >= 0);
      checks++;
      if (host_bus.host_intr_req !== exp_req) begin
        errors++;
        $display("[TB] FAIL rnd_req cycle %0d: got %b expected %b", n, host_bus.host_intr_req, exp_req);
      end
      checks++;
      if (kern_intr_ack !== kack_e) begin
        errors++;
        $display("[TB] FAIL rnd_ack cycle %0d: got %b expected %b", n, kern_intr_ack, kack_e);
      end
      checks++;
      if (busy !== busy_e || overrun_err !== over_m) begin
        errors++;
        $display("[TB] FAIL rnd_status cycle %0d: got busy=%b ovr=%b expected busy=%b ovr=%b", n, busy, overrun_err, busy_e, over_m);
      end
      if (exp_req) begin
        checks++;
        if (host_bus.host_intr_src !== cur_src || host_bus.host_intr_ctx !== cur_ctx) begin
          errors++;
          $display("[TB] FAIL rnd_payload cycle %0d: got %h/%h expected %h/%h", n,
                   host_bus.host_intr_src, host_bus.host_intr_ctx, cur_src, cur_ctx);
        end
      end
      if (ack_due >= 0) begin
        last_m  = ack_due;
        ack_due = -1;
      end else if (txn_k >= 0 && gap == 0) begin
        if (hack) begin
          if (herr) gap = RD;
          else begin
            ack_due = txn_k;
            txn_k   = -1;
          end
        end
      end else if (txn_k >= 0) begin
        gap--;
      end else if (pend_m != '0) begin
        txn_k   = arb_pick(pend_m, last_m);
        cur_src = src_m[txn_k];
        cur_ctx = ctx_m[txn_k];
      end
      for (int k = 0; k < NK; k++) begin
        if (kreq[k]) begin
          if (pend_m[k] && !kack_e[k]) over_m[k] = 1'b1;
          else begin
            pend_m[k] = 1'b1;
            src_m[k]  = kern_intr_src[64*k +: 64];
            ctx_m[k]  = kern_intr_ctx[CTXW*k +: CTXW];
          end
        end else if (kack_e[k]) begin
          pend_m[k] = 1'b0;
        end
      end
      exp_req = (txn_k >= 0) && (gap == 0);
    end
    tick();
    kern_intr_req          = '0;
    host_bus.host_intr_ack = 1'b0;
    host_bus.host_intr_err = 1'b0;
  endtask

  initial begin
    host_bus.host_intr_ack = 1'b0;
    host_bus.host_intr_err = 1'b0;
    for (int k = 0; k < NK; k++) begin
      sent_src[k] = '0;
      sent_ctx[k] = '0;
    end
    test_reset();
    test_single();
    test_simultaneous();
    test_fairness();
    test_retry();
    test_overrun();
    test_reset_mid_req();
`ifdef KERNEL_INTR_TIMEOUT_EN
    test_timeout();
`endif
    test_random(3000);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
